// File: rtl/spi_mem_master_if.sv
// CPU-side request/data bus of the SPI memory master.
// The master modport is the requester; the slave modport is the SPI engine.
interface spi_mem_master_if #(
   parameter int ADDR_W = 24,
   parameter int LEN_W  = 4,
   parameter int CS_W   = 1
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [CS_W-1:0]   req_cs;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic [7:0]        wr_data;
   logic              wr_ready;
   logic [7:0]        rd_data;
   logic              rd_valid;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output req_valid, req_write, req_cs, req_addr, req_len, wr_data,
      input  req_ready, wr_ready, rd_data, rd_valid, busy, done, err
   );

   modport slave (
      input  req_valid, req_write, req_cs, req_addr, req_len, wr_data,
      output req_ready, wr_ready, rd_data, rd_valid, busy, done, err
   );
endinterface

// File: rtl/spi_mem_master.sv
// SPI mode-0 memory master: 0x03 read / 0x02 write with address and byte bursts,
// NUM_CS chip selects and a run-time SCLK divider latched per transaction.
module spi_mem_master #(
   parameter int NUM_CS = 2,
   parameter int ADDR_W = 24,
   parameter int LEN_W  = 4,
   parameter int DIV_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DIV_W-1:0]  cfg_div,
   spi_mem_master_if.slave   bus,
   output logic              sclk_out,
   output logic [NUM_CS-1:0] cs_n_out,
   output logic              mosi_out,
   input  logic              miso_in
);
   localparam int SH_W = 8 + ADDR_W;
   localparam int BC_W = $clog2((ADDR_W > 8) ? ADDR_W : 8);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DESEL} state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d, hcnt_q, hcnt_d;
   logic              sclk_q, sclk_d;
   logic [NUM_CS-1:0] cs_n_q, cs_n_d;
   logic [SH_W-1:0]   sh_q, sh_d;
   logic [BC_W-1:0]   bcnt_q, bcnt_d;
   logic [LEN_W-1:0]  left_q, left_d;
   logic              write_q, write_d;
   logic [7:0]        rx_q, rx_d, rd_data_q, rd_data_d;
   logic              rx_fire_q, rx_fire_d, rd_valid_q, rd_valid_d;
   logic              done_q, done_d, err_q, err_d, busy_q, busy_d;
   logic              wr_ready;
   logic              toggle, last_bit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         hcnt_q     <= '0;
         sclk_q     <= 1'b0;
         cs_n_q     <= '1;
         sh_q       <= '0;
         bcnt_q     <= '0;
         left_q     <= '0;
         write_q    <= 1'b0;
         rx_q       <= '0;
         rd_data_q  <= '0;
         rx_fire_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         hcnt_q     <= hcnt_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         sh_q       <= sh_d;
         bcnt_q     <= bcnt_d;
         left_q     <= left_d;
         write_q    <= write_d;
         rx_q       <= rx_d;
         rd_data_q  <= rd_data_d;
         rx_fire_q  <= rx_fire_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      hcnt_d     = hcnt_q;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      sh_d       = sh_q;
      bcnt_d     = bcnt_q;
      left_d     = left_q;
      write_d    = write_q;
      rx_d       = rx_q;
      rd_data_d  = rd_data_q;
      rx_fire_d  = 1'b0;
      rd_valid_d = rx_fire_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      busy_d     = busy_q;
      wr_ready   = 1'b0;
      toggle     = (hcnt_q == div_q);
      last_bit   = (state_q == S_ADDR) ? (bcnt_q == BC_W'(ADDR_W - 1))
                                       : (bcnt_q == BC_W'(7));

      // rd_valid trails the final sampling edge of a byte by one cycle
      if (rx_fire_q) rd_data_d = rx_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (int'(bus.req_cs) >= NUM_CS) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  state_d = S_CMD;
                  div_d   = cfg_div;
                  hcnt_d  = '0;
                  sclk_d  = 1'b0;
                  cs_n_d  = '1;
                  cs_n_d[bus.req_cs] = 1'b0;
                  sh_d    = {(bus.req_write ? 8'h02 : 8'h03), bus.req_addr};
                  bcnt_d  = '0;
                  left_d  = bus.req_len;
                  write_d = bus.req_write;
                  busy_d  = 1'b1;
               end
            end
         end

         S_CMD, S_ADDR, S_DATA: begin
            if (!toggle) begin
               hcnt_d = hcnt_q + 1'b1;
            end else begin
               hcnt_d = '0;
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  if (state_q == S_DATA && !write_q) begin
                     rx_d      = {rx_q[6:0], miso_in};
                     rx_fire_d = (bcnt_q == BC_W'(7));
                  end
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
                  sh_d   = sh_q << 1;
                  if (last_bit) begin
                     bcnt_d = '0;
                     if (state_q == S_CMD) begin
                        state_d = S_ADDR;
                     end else if (state_q == S_DATA && left_q == '0) begin
                        state_d = S_DESEL;
                        cs_n_d  = '1;
                        sh_d    = '0;
                     end else begin
                        // the falling edge that ends the address or a byte launches the next data byte
                        if (state_q == S_DATA) left_d = left_q - 1'b1;
                        state_d = S_DATA;
                        if (write_q) begin
                           wr_ready = 1'b1;
                           sh_d     = {bus.wr_data, {ADDR_W{1'b0}}};
                        end else begin
                           sh_d = '0;
                        end
                     end
                  end
               end
            end
         end

         S_DESEL: begin
            if (toggle) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.wr_ready  = wr_ready;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign sclk_out      = sclk_q;
   assign cs_n_out      = cs_n_q;
   assign mosi_out      = sh_q[SH_W-1];
endmodule

// File: doc/spi_mem_master.md
Name: spi_mem_master

Overview:
Parametrised SPI-bus memory master that replaces the hard-wired flash/PSRAM pin pair behind the tiny MCU top. It supports NUM_CS chip selects, a configurable address width, multi-byte bursts, a run-time clock divider, and both read (0x03) and write (0x02) transactions. The CPU side uses a valid/ready request with byte-streamed data; the pin side is SPI mode 0 with a single MOSI/MISO pair.

Parameters:
NUM_CS, 2, number of chip selects (index 0 = flash, 1 = PSRAM by convention)
ADDR_W, 24, address bits shifted after the command byte, MSB first
LEN_W, 4, burst length field width; byte count = req_len+1 (1..2^LEN_W)
DIV_W, 4, width of cfg_div

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
cfg_div  in  DIV_W  SCLK half-period = cfg_div+1 clk cycles (H), sampled at request accept
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_write  in  1  1 = write (cmd 0x02), 0 = read (cmd 0x03)
req_cs  in  max(1,$clog2(NUM_CS))  chip-select index
req_addr  in  ADDR_W  start address
req_len  in  LEN_W  bytes-1
wr_data  in  8  write byte, captured when wr_ready=1
wr_ready  out  1  1-cycle pulse: wr_data consumed this cycle
rd_data  out  8  last received byte
rd_valid  out  1  1-cycle pulse: rd_data new
busy  out  1  high from accept cycle+1 until done
done  out  1  1-cycle pulse at transaction end
err  out  1  valid with done; 1 = req_cs >= NUM_CS
sclk_out  out  1  SPI clock, idle low
cs_n_out  out  NUM_CS  active-low selects
mosi_out  out  1  serial out
miso_in  in  1  serial in

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; sclk_out=0, cs_n_out=all 1, mosi_out=0, rd_data=0, rd_valid/wr_ready/done/err/busy=0, req_ready=1. Reset mid-transaction aborts it: CS released on the next edge, no done.
- Accept when req_valid&&req_ready (cycle T). Latch all req_* fields and cfg_div. req_valid is ignored while busy.
- Invalid req_cs: no CS/SCLK activity; done=1, err=1 at T+1; back to IDLE.
- States: IDLE -> CMD (8 bits) -> ADDR (ADDR_W bits) -> DATA (8*(len+1) bits) -> DESEL (H cycles) -> IDLE. Total bits N = 8+ADDR_W+8*(len+1).
- Mode 0 timing: at T+1 selected cs_n goes low and mosi carries bit 0 (cmd MSB). Bit k rising edge at T+1+2Hk+H, falling edge at T+1+2H(k+1). MOSI updates on falling edges. MISO is sampled on rising edges.
- After the last falling edge (T+1+2HN): cs_n all high, sclk low, mosi 0, DESEL for H cycles. done=1, busy=0, req_ready=1 at T+1+2HN+H.
- Write: wr_ready pulses the cycle before the falling edge that starts each data byte, and wr_data is captured on that cycle. There is no backpressure; the source must have data ready.
- Write: MISO is ignored. Read: MOSI is 0 during DATA.
- Read: rd_valid pulses the cycle after the 8th rising edge of each byte. rd_data holds until the next byte.
- len at max (2^LEN_W bytes) has no address wrap logic; the address is sent once and the device auto-increments.
- cfg_div changes mid-transaction have no effect.

Test Plan:
- Reset: hold rst_n=0 2 cycles mid-burst -> cs_n=2'b11, sclk=0, done never pulses, req_ready=1 next cycle.
- Read, cfg_div=0, cs=1, addr=0x000010, len=0; MISO model returns 0xA5 -> MOSI 0x03,0x00,0x00,0x10; cs_n=2'b01 cycles T+1..T+80; rd_valid once with rd_data=0xA5; done at T+82.
- Write, cfg_div=2 (H=3), cs=0, addr=0x123456, len=2, data 0x11,0x22,0x33 -> 3 wr_ready pulses; MOSI 0x02,0x12,0x34,0x56,0x11,0x22,0x33; sclk high/low each 3 cycles; done at T+1+6*56+3=T+340.
- Read burst, len=15 -> 16 rd_valid pulses, spaced 16*H cycles apart, data matches the model.
- req_cs=2 with NUM_CS=2 -> done=err=1 at T+1, cs_n stays 2'b11, sclk never toggles.
- req_valid held high through a transaction -> exactly one accept per done. The second accept occurs on the done cycle (req_ready=1).
